uart_tx_gen2: RTL and testbench

UART_TX_GEN2 -- requirements
Module: uart_tx_gen2

---
 rtl/uart_tx_pkg.sv | 39 +++
 rtl/uart_tx_gen2_if.sv | 15 +
 rtl/uart_tx_osr_cnt.sv | 35 +++
 rtl/uart_tx_gen2.sv | 194 +++++++++++++++++++
 tb/tb_uart_tx_gen2.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the uart_tx_gen2 transmitter.
//   state_e      : transmitter FSM encoding
//   wls_e        : word-length-select encodings (wls = word length - 5)
//   OSR/DW       : defaults and legal limits for the top-level parameters
//   wlen_of()    : maps a wls code to the effective word length, clamped to DW
package uart_tx_pkg;

  localparam int unsigned OSR_DEF  = 16;
  localparam int unsigned OSR_MIN  = 4;
  localparam int unsigned OSR_MAX  = 16;
  localparam int unsigned DW_DEF   = 9;
  localparam int unsigned DW_MIN   = 5;
  localparam int unsigned DW_MAX   = 9;
  localparam int unsigned WLEN_MIN = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    WLS_5 = 3'd0,
    WLS_6 = 3'd1,
    WLS_7 = 3'd2,
    WLS_8 = 3'd3,
    WLS_9 = 3'd4
  } wls_e;

  // Codes beyond what DW can carry select the widest word DW supports.
  function automatic logic [3:0] wlen_of(input logic [2:0] wls, input int unsigned dw);
    logic [2:0] max_wls;
    max_wls = 3'(dw - WLEN_MIN);
    return (wls > max_wls) ? 4'(dw) : 4'(WLEN_MIN) + 4'(wls);
  endfunction

endpackage

// File: rtl/uart_tx_gen2_if.sv
// Write handshake between a producer and the uart_tx_gen2 transmitter.
//   tx_valid : producer has a word to send
//   tx_data  : word to send (DW bits, LSB transmitted first)
//   tx_ready : transmitter can accept a word this cycle
// Modports: master = producer, slave = transmitter.
interface uart_tx_gen2_if #(
  parameter int unsigned DW = 9
) ();
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_osr_cnt.sv
// Oversample counter for uart_tx_gen2.
//   pclk, preset : clock and synchronous active-high reset
//   i_en         : count enable; counter is held at 0 while low
//   bclk         : oversample tick, one pclk wide
//   o_bit_end    : last tick of a full bit (bclk & cnt == OSR-1)
//   o_half_end   : last tick of a half bit (bclk & cnt == OSR/2-1)
module uart_tx_osr_cnt #(
  parameter int unsigned OSR = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic i_en,
  input  logic bclk,
  output logic o_bit_end,
  output logic o_half_end
);

  localparam int unsigned CW = $clog2(OSR);

  logic [CW-1:0] r_cnt;

  assign o_bit_end  = bclk && (r_cnt == CW'(OSR - 1));
  assign o_half_end = bclk && (r_cnt == CW'(OSR / 2 - 1));

  always_ff @(posedge pclk) begin
    if (preset || !i_en) begin
      r_cnt <= '0;
    end else if (o_bit_end) begin
      r_cnt <= '0;
    end else if (bclk) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_gen2.sv
// UART transmitter with configurable word length, parity and stop bits.
// Parameters: OSR (bclk ticks per bit, even, 4..16), DW (max data width, 5..9).
// Ports:
//   pclk, preset         : clock, synchronous active-high reset
//   bclk                 : one-pclk-wide oversample tick at OSR x baud
//   tx_if (slave)        : tx_valid / tx_data / tx_ready write handshake
//   wls                  : word length select (5 + wls, clamped to DW)
//   pen, eps, sp, stb    : parity enable, even parity, stick parity, 2-stop select
//   brk                  : break request (active only with UART_TX_BREAK_EN)
//   tx_busy, tx_done     : frame in progress, one-cycle end-of-frame pulse
//   uart_txd             : registered serial output, idles high
// Build option: define UART_TX_BREAK_EN to enable break generation on brk.
module uart_tx_gen2
  import uart_tx_pkg::*;
#(
  parameter int unsigned OSR = OSR_DEF,
  parameter int unsigned DW  = DW_DEF
) (
  input  logic           pclk,
  input  logic           preset,
  input  logic           bclk,
  uart_tx_gen2_if.slave  tx_if,
  input  logic [2:0]     wls,
  input  logic           pen,
  input  logic           eps,
  input  logic           sp,
  input  logic           stb,
  input  logic           brk,
  output logic           tx_busy,
  output logic           tx_done,
  output logic           uart_txd
);

  if (OSR < OSR_MIN || OSR > OSR_MAX || (OSR % 2) != 0 || DW < DW_MIN || DW > DW_MAX) begin : g_bad_param
    $error("uart_tx_gen2: OSR must be even in 4..16 and DW in 5..9");
  end

  state_e        r_state;
  logic [DW-1:0] r_shift;
  logic [3:0]    r_bitcnt;
  logic [3:0]    r_wlen;
  logic          r_pen;
  logic          r_stb;
  logic          r_par;
  logic          r_txd;
  logic          r_done;

  state_e        w_state_nxt;
  logic [DW-1:0] w_shift_nxt;
  logic [3:0]    w_bitcnt_nxt;
  logic          w_txd_nxt;
  logic          w_stop_end;
  logic          w_accept;
  logic          w_bit_end;
  logic          w_half_end;
  logic [3:0]    w_wlen_in;
  logic [DW-1:0] w_mask;
  logic          w_par_data;
  logic          w_par_in;

  assign tx_if.tx_ready = (r_state == IDLE) && !preset;
  assign w_accept       = tx_if.tx_valid && tx_if.tx_ready;
  assign tx_busy        = (r_state != IDLE);
  assign tx_done        = r_done;
  assign uart_txd       = r_txd;

  uart_tx_osr_cnt #(
    .OSR (OSR)
  ) u_osr_cnt (
    .pclk       (pclk),
    .preset     (preset),
    .i_en       (r_state != IDLE),
    .bclk       (bclk),
    .o_bit_end  (w_bit_end),
    .o_half_end (w_half_end)
  );

  // Parity bit is resolved at accept time from the incoming word, so the
  // frame never depends on config inputs after the handshake.
  assign w_wlen_in = wlen_of(wls, DW);

  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      w_mask[i] = (i < 32'(w_wlen_in));
    end
    w_par_data = ^(tx_if.tx_data & w_mask);
    if (sp) begin
      w_par_in = ~eps;
    end else begin
      w_par_in = eps ? w_par_data : ~w_par_data;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_stop_end   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt  = START;
          w_shift_nxt  = tx_if.tx_data;
          w_bitcnt_nxt = '0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt  = DATA;
          w_bitcnt_nxt = '0;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bitcnt == r_wlen - 4'd1) begin
            w_state_nxt  = r_pen ? PARITY : STOP;
            w_bitcnt_nxt = '0;
          end else begin
            w_bitcnt_nxt = r_bitcnt + 4'd1;
            w_shift_nxt  = r_shift >> 1;
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt  = STOP;
          w_bitcnt_nxt = '0;
        end
      end
      STOP: begin
        // Second stop period is a half bit for 5-bit words, a full bit otherwise.
        if (!r_stb) begin
          w_stop_end = w_bit_end;
        end else if (r_bitcnt == '0) begin
          if (w_bit_end) w_bitcnt_nxt = 4'd1;
        end else if (r_wlen == 4'(WLEN_MIN)) begin
          w_stop_end = w_half_end;
        end else begin
          w_stop_end = w_bit_end;
        end
        if (w_stop_end) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Line level is derived from the next state so uart_txd is a plain flop.
  always_comb begin
    w_txd_nxt = 1'b1;
    unique case (w_state_nxt)
      START:   w_txd_nxt = 1'b0;
      DATA:    w_txd_nxt = w_shift_nxt[0];
      PARITY:  w_txd_nxt = r_par;
      default: w_txd_nxt = 1'b1;
    endcase
  end

`ifndef UART_TX_BREAK_EN
  logic w_unused_brk;
  assign w_unused_brk = brk;
`endif

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_wlen   <= '0;
      r_pen    <= 1'b0;
      r_stb    <= 1'b0;
      r_par    <= 1'b0;
      r_txd    <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_done   <= w_stop_end;
`ifdef UART_TX_BREAK_EN
      r_txd    <= brk ? 1'b0 : w_txd_nxt;
`else
      r_txd    <= w_txd_nxt;
`endif
      if (w_accept) begin
        r_wlen <= w_wlen_in;
        r_pen  <= pen;
        r_stb  <= stb;
        r_par  <= w_par_in;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_gen2.sv
// Self-checking bench for uart_tx_gen2 (OSR=16, DW=9).
// Expected frames are hand-written as bit strings (start, data LSB first,
// parity) plus stop length in ticks; a monitor records the line once per
// bclk tick while busy and compares against the queued frame on tx_done.
module tb_uart_tx_gen2;

  localparam int unsigned OSR = 16;
  localparam int unsigned DW  = 9;

  logic       pclk;
  logic       preset;
  logic       bclk;
  logic [2:0] wls;
  logic       pen, eps, sp, stb, brk;
  logic       tx_busy, tx_done, uart_txd;

  uart_tx_gen2_if #(.DW(DW)) u_if ();

  uart_tx_gen2 #(.OSR(OSR), .DW(DW)) dut (
    .pclk     (pclk),
    .preset   (preset),
    .bclk     (bclk),
    .tx_if    (u_if),
    .wls      (wls),
    .pen      (pen),
    .eps      (eps),
    .sp       (sp),
    .stb      (stb),
    .brk      (brk),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .uart_txd (uart_txd)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // bclk: one cycle high out of every three
  initial begin
    bclk = 1'b0;
    forever begin
      repeat (2) @(posedge pclk);
      #1 bclk = 1'b1;
      @(posedge pclk);
      #1 bclk = 1'b0;
    end
  end

  typedef struct {
    logic [255:0] vec;
    int unsigned  len;
    string        name;
    bit           chk;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

`ifdef UART_TX_BREAK_EN
  localparam bit BRK_FRAME_CHK = 1'b0;
`else
  localparam bit BRK_FRAME_CHK = 1'b1;
`endif

  function automatic exp_t build(input string bits, input int unsigned stop_ticks,
                                 input string name, input bit chk);
    exp_t e;
    int unsigned k;
    e.vec = '0;
    k = 0;
    for (int i = 0; i < bits.len(); i++) begin
      for (int unsigned t = 0; t < OSR; t++) begin
        e.vec[k[7:0]] = (bits[i] == "1");
        k++;
      end
    end
    for (int unsigned t = 0; t < stop_ticks; t++) begin
      e.vec[k[7:0]] = 1'b1;
      k++;
    end
    e.len  = k;
    e.name = name;
    e.chk  = chk;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor
  logic [255:0] rec;
  int unsigned  rec_len;

  initial begin
    exp_t e;
    rec     = '0;
    rec_len = 0;
    forever begin
      @(negedge pclk);
      if (preset) begin
        rec     = '0;
        rec_len = 0;
      end else if (tx_done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          e = sb.pop_front();
          if (e.chk) begin
            checks++;
            if (rec_len != e.len || rec != e.vec) begin
              errors++;
              $display("FAIL frame_%s actual len=%0d line=%h required len=%0d line=%h",
                       e.name, rec_len, rec, e.len, e.vec);
            end
          end
        end
        rec     = '0;
        rec_len = 0;
      end else if (tx_busy && bclk) begin
        if (rec_len < 256) rec[rec_len[7:0]] = uart_txd;
        rec_len++;
      end
    end
  end

  task automatic accept(input logic [8:0] d, input logic [2:0] w,
                        input logic p, input logic e, input logic s, input logic st,
                        input string bits, input int unsigned stop_ticks,
                        input string name, input bit chk, input bit push);
    int unsigned n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    @(posedge pclk);
    #1;
    u_if.tx_valid = 1'b1;
    u_if.tx_data  = d;
    wls = w; pen = p; eps = e; sp = s; stb = st;
    while (!ok && n < 3000) begin
      @(negedge pclk);
      n++;
      if (u_if.tx_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout_%s actual=0 required=1", name);
      u_if.tx_valid = 1'b0;
      return;
    end
    @(posedge pclk);
    if (push) sb.push_back(build(bits, stop_ticks, name, chk));
    #1;
    // Scramble data and config after the handshake; the frame must not change.
    u_if.tx_valid = 1'b0;
    u_if.tx_data  = ~d;
    wls = ~w; pen = ~p; eps = ~e; sp = ~s; stb = ~st;
  endtask

  task automatic wait_done(input string name);
    int unsigned n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 3000) begin
      @(negedge pclk);
      n++;
      if (tx_done) seen = 1'b1;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({name, "_ready_at_done"}, 32'(u_if.tx_ready), 32'd1);
      check({name, "_busy_at_done"}, 32'(tx_busy), 32'd0);
    end
  endtask

  task automatic frame(input logic [8:0] d, input logic [2:0] w,
                       input logic p, input logic e, input logic s, input logic st,
                       input string bits, input int unsigned stop_ticks, input string name);
    accept(d, w, p, e, s, st, bits, stop_ticks, name, 1'b1, 1'b1);
    wait_done(name);
  endtask

  task automatic wait_ticks(input int unsigned ticks);
    int unsigned t;
    int unsigned n;
    t = 0;
    n = 0;
    while (t < ticks && n < 10000) begin
      @(negedge pclk);
      n++;
      if (bclk) t++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0]  bb_data [3];
    string       bb_bits [3];
    int unsigned acc, rc, cyc, dones, bad;

    preset        = 1'b1;
    u_if.tx_valid = 1'b0;
    u_if.tx_data  = '0;
    wls = 3'd0; pen = 0; eps = 0; sp = 0; stb = 0; brk = 0;

    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_txd",   32'(uart_txd),      32'd1);
    check("rst_ready", 32'(u_if.tx_ready), 32'd0);
    check("rst_busy",  32'(tx_busy),       32'd0);
    check("rst_done",  32'(tx_done),       32'd0);
    @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    check("ready_after_reset", 32'(u_if.tx_ready), 32'd1);

    //     data    wls   pen eps sp stb  expected bits             stop  name
    frame(9'h055, 3'd3, 0, 0, 0, 0, "010101010",               16, "d55_8n1");
    frame(9'h1A5, 3'd4, 1, 1, 0, 0, "01010010111",             16, "d1a5_9e1");
    frame(9'h1A5, 3'd4, 1, 0, 0, 0, "01010010110",             16, "d1a5_9o1");
    frame(9'h0F3, 3'd0, 1, 1, 0, 1, "0110011",                 24, "d0f3_5e15");
    frame(9'h0A0, 3'd3, 0, 0, 0, 1, "000000101",               32, "da0_8n2");
    frame(9'h001, 3'd3, 1, 0, 1, 0, "0100000001",              16, "stick_eps0");
    frame(9'h0FF, 3'd3, 1, 1, 1, 0, "0111111110",              16, "stick_eps1");
    frame(9'h100, 3'd7, 0, 0, 0, 0, "0000000001",              16, "wls_clamp");
    frame(9'h02B, 3'd1, 1, 0, 0, 0, "01101011",                16, "d2b_6o1");
    frame(9'h03C, 3'd3, 1, 1, 0, 0, "0001111000",              16, "cfg_midframe");

    // tx_valid held across three frames
    bb_data = '{9'h011, 9'h022, 9'h033};
    bb_bits = '{"010001000", "001000100", "011001100"};
    @(posedge pclk);
    #1;
    wls = 3'd3; pen = 0; eps = 0; sp = 0; stb = 0;
    u_if.tx_valid = 1'b1;
    u_if.tx_data  = bb_data[0];
    acc = 0; rc = 0; cyc = 0;
    while (acc < 3 && cyc < 6000) begin
      @(negedge pclk);
      cyc++;
      if (u_if.tx_ready) begin
        rc++;
        @(posedge pclk);
        sb.push_back(build(bb_bits[acc], 16, $sformatf("b2b%0d", acc), 1'b1));
        acc++;
        #1;
        if (acc < 3) u_if.tx_data = bb_data[acc];
        else         u_if.tx_valid = 1'b0;
      end
    end
    check("b2b_accepts",      acc, 32'd3);
    check("b2b_ready_cycles", rc,  32'd3);
    wait_done("b2b");

    // Reset in the middle of DATA
    accept(9'h000, 3'd3, 0, 0, 0, 0, "", 0, "abort", 1'b0, 1'b0);
    wait_ticks(40);
    check("pre_rst_txd", 32'(uart_txd), 32'd0);
    @(posedge pclk);
    #1 preset = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    check("midrst_txd",   32'(uart_txd),      32'd1);
    check("midrst_busy",  32'(tx_busy),       32'd0);
    check("midrst_ready", 32'(u_if.tx_ready), 32'd0);
    @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    check("midrst_ready_after", 32'(u_if.tx_ready), 32'd1);
    dones = 0;
    repeat (300) begin
      @(negedge pclk);
      if (tx_done) dones++;
    end
    check("midrst_no_done", dones, 32'd0);

    // Break request for 100 ticks in the middle of a frame
    accept(9'h00F, 3'd3, 0, 0, 0, 0, "011110000", 16, "brk_frame", BRK_FRAME_CHK, 1'b1);
    wait_ticks(20);
    @(posedge pclk);
    #1 brk = 1'b1;
    @(posedge pclk);
    bad = 0;
    cyc = 0;
    acc = 0;
    while (acc < 100 && cyc < 10000) begin
      @(negedge pclk);
      cyc++;
      if (bclk) acc++;
      if (uart_txd !== 1'b0) bad++;
    end
`ifdef UART_TX_BREAK_EN
    check("brk_line_low", bad, 32'd0);
`endif
    @(posedge pclk);
    #1 brk = 1'b0;
    wait_done("brk");

    repeat (10) @(negedge pclk);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
